line_feed_scheduler: RTL and testbench

//  Sequences pixel delivery into the 4-line-buffer image controller. Reads a frame row-by-row from frame

---
 rtl/img_pkg.sv | 18 +
 rtl/line_feed_scheduler.sv | 176 +++++++++++++++++
 tb/tb_line_feed_scheduler.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared definitions for the image line-buffer subsystem: default frame
// geometry and the scheduler state encoding, also used by the controller bench.
package img_pkg;

    localparam int IMG_WIDTH_DEF  = 512;
    localparam int IMG_HEIGHT_DEF = 512;
    localparam int PAD_LINES_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_WAIT  = 3'd2,
        ST_LINE  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/line_feed_scheduler.sv
// Line feed scheduler: reads a frame line-by-line from frame memory, primes
// the image controller with a few lines, then releases one line per row
// interrupt, appends zero pad lines and reports completion.
module line_feed_scheduler
    import img_pkg::*;
#(
    parameter int IMG_WIDTH   = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT  = IMG_HEIGHT_DEF,
    parameter int PRIME_LINES = 4,
    parameter int PAD_LINES   = PAD_LINES_DEF,
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    output logic              o_mem_rd_en,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    output logic [DATA_W-1:0] o_pixel_data,
    output logic              o_pixel_data_valid,
    input  logic              i_intr,
    output logic              o_busy,
    output logic              o_done,
    output logic [15:0]       o_rows_done
);

    localparam int TOTAL_LINES = IMG_HEIGHT + PAD_LINES;
    localparam int TOTAL_ROWS  = TOTAL_LINES - 2;
    localparam int PRIME_TGT   = (PRIME_LINES < TOTAL_LINES) ? PRIME_LINES : TOTAL_LINES;
    localparam int COL_W       = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;

    localparam logic [15:0]      HEIGHT_V      = 16'(IMG_HEIGHT);
    localparam logic [15:0]      TOTAL_LINES_V = 16'(TOTAL_LINES);
    localparam logic [15:0]      TOTAL_ROWS_V  = 16'(TOTAL_ROWS);
    localparam logic [15:0]      PRIME_TGT_V   = 16'(PRIME_TGT);
    localparam logic [COL_W-1:0] LAST_COL      = COL_W'(IMG_WIDTH - 1);

    sched_state_t      state, state_nx;
    logic [COL_W-1:0]  col;
    logic [15:0]       lines_sent;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] offset;
    logic [2:0]        credit;
    logic [15:0]       rows_done;
    logic              vld_p1;
    logic              pad_p1;

    logic streaming;
    logic is_image;
    logic last_px;
    logic accept_start;
    logic consume;
    logic intr_cnt;

    // Credit update: an interrupt adds one (capped at 7), a line start takes one.
    function automatic logic [2:0] credit_next(input logic [2:0] c,
                                               input logic inc,
                                               input logic dec);
        if (inc && !dec)
            return (c == 3'd7) ? 3'd7 : c + 3'd1;
        else if (dec && !inc)
            return c - 3'd1;
        else
            return c;
    endfunction

    assign streaming    = (state == ST_PRIME) || (state == ST_LINE);
    assign is_image     = (lines_sent < HEIGHT_V);
    assign last_px      = streaming && (col == LAST_COL);
    assign accept_start = (state == ST_IDLE) && i_start && !i_abort;
    assign consume      = (state == ST_WAIT) && (credit != 3'd0) && (lines_sent < TOTAL_LINES_V);
    assign intr_cnt     = i_intr && (state != ST_IDLE);

    assign o_mem_addr         = base_q + offset;
    assign o_pixel_data_valid = vld_p1;
    assign o_pixel_data       = (vld_p1 && !pad_p1) ? i_mem_rd_data : '0;
    assign o_rows_done        = rows_done;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Next-state sequencing and control strobes; abort overrides every state.
    always_comb begin
        state_nx    = state;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_mem_rd_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept_start)
                    state_nx = ST_PRIME;
            end
            ST_PRIME: begin
                o_busy      = 1'b1;
                o_mem_rd_en = is_image;
                if (last_px && (lines_sent + 16'd1 >= PRIME_TGT_V))
                    state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                if (lines_sent >= TOTAL_LINES_V)
                    state_nx = ST_DRAIN;
                else if (credit != 3'd0)
                    state_nx = ST_LINE;
            end
            ST_LINE: begin
                o_busy      = 1'b1;
                o_mem_rd_en = is_image;
                if (last_px)
                    state_nx = ST_WAIT;
            end
            ST_DRAIN: begin
                o_busy = 1'b1;
                if (rows_done >= TOTAL_ROWS_V)
                    state_nx = ST_DONE;
            end
            ST_DONE: begin
                o_done   = 1'b1;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
        if (i_abort)
            state_nx = ST_IDLE;
    end

    // Column, line, address-offset, credit and row counters; cleared on each accepted start.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            base_q     <= '0;
            offset     <= '0;
            col        <= '0;
            lines_sent <= '0;
            credit     <= '0;
            rows_done  <= '0;
        end else if (accept_start) begin
            base_q     <= i_base_addr;
            offset     <= '0;
            col        <= '0;
            lines_sent <= '0;
            credit     <= '0;
            rows_done  <= '0;
        end else begin
            if (streaming) begin
                col <= last_px ? '0 : col + COL_W'(1);
                if (last_px)
                    lines_sent <= lines_sent + 16'd1;
                if (is_image)
                    offset <= offset + ADDR_W'(1);
            end
            credit <= credit_next(credit, intr_cnt, consume);
            if (intr_cnt)
                rows_done <= rows_done + 16'd1;
        end
    end

    // p0 -> p1: pixel strobe follows the read strobe by one cycle, pad lines ride the same slot.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vld_p1 <= 1'b0;
            pad_p1 <= 1'b0;
        end else begin
            vld_p1 <= streaming;
            pad_p1 <= streaming && !is_image;
        end
    end

endmodule

// File: tb/tb_line_feed_scheduler.sv
// Bench for line_feed_scheduler with a small 8x6 frame, a random-content
// frame memory and a line-count / pixel-stream reference model.
module tb_line_feed_scheduler;

    localparam int W         = 8;
    localparam int H         = 6;
    localparam int PAD       = 2;
    localparam int PRIME     = 4;
    localparam int AW        = 18;
    localparam int TOT_LINES = H + PAD;
    localparam int TOT_ROWS  = TOT_LINES - 2;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          intr  = 1'b0;
    logic [AW-1:0] base  = '0;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [7:0]    rd_data = '0;
    logic [7:0]    px;
    logic          pv;
    logic          busy;
    logic          done;
    logic [15:0]   rows;

    int errors   = 0;
    int checks   = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic [7:0]    got_px[$];
    logic [AW-1:0] got_addr[$];
    int            vcyc[$];

    line_feed_scheduler #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(PRIME),
        .PAD_LINES(PAD), .ADDR_W(AW), .DATA_W(8)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_abort(abort),
        .i_base_addr(base), .o_mem_rd_en(rd_en), .o_mem_addr(addr),
        .i_mem_rd_data(rd_data), .o_pixel_data(px), .o_pixel_data_valid(pv),
        .i_intr(intr), .o_busy(busy), .o_done(done), .o_rows_done(rows)
    );

    always #5 clk = ~clk;

    // Frame memory: one-cycle read latency.
    always @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[addr];
    end

    // Monitor, sampling just after each rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (pv) begin
                got_px.push_back(px);
                vcyc.push_back(cyc);
            end
            if (rd_en)
                got_addr.push_back(addr);
            if (done)
                done_cnt = done_cnt + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: pixel idx of the frame stream, image lines from memory, pad lines zero.
    function automatic logic [7:0] exp_px(input logic [AW-1:0] b, input int idx);
        logic [AW-1:0] a;
        if (idx / W >= H)
            return 8'h00;
        a = b + AW'(idx);
        return mem[a];
    endfunction

    // Reference: lines the scheduler may deliver after n interrupts.
    function automatic int exp_lines(input int n_intr);
        int l;
        l = PRIME + n_intr;
        return (l < TOT_LINES) ? l : TOT_LINES;
    endfunction

    task automatic clear_mon();
        got_px.delete();
        got_addr.delete();
        vcyc.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b);
        @(negedge clk);
        base  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic pulse_intr();
        @(negedge clk);
        intr = 1'b1;
        @(negedge clk);
        intr = 1'b0;
    endtask

    task automatic wait_px(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_px.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (got_addr.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic random_base(output logic [AW-1:0] b);
        b = AW'($urandom_range(0, (1 << AW) - 1));
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        checks++; if (addr !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", addr); end
        checks++; if (pv !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pv); end
        checks++; if (px !== 8'h00) begin errors++; $display("FAIL reset_pixel: got %h want 0", px); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rows !== 16'd0) begin errors++; $display("FAIL reset_rows: got %0d want 0", rows); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++; $display("FAIL reset_release_idle: busy=%b rd_en=%b want 0 0", busy, rd_en);
        end
    endtask

    task automatic test_prime();
        logic [AW-1:0] b;
        bit seq_ok;
        b = 18'h100;
        clear_mon();
        do_start(b);
        repeat (60) @(negedge clk);
        checks++; if (got_addr.size() != PRIME * W) begin
            errors++; $display("FAIL prime_reads: got %0d want %0d", got_addr.size(), PRIME * W);
        end
        checks++; if (got_px.size() != PRIME * W) begin
            errors++; $display("FAIL prime_valids: got %0d want %0d", got_px.size(), PRIME * W);
        end
        for (int i = 0; i < got_addr.size() && i < PRIME * W; i++) begin
            checks++; if (got_addr[i] !== b + AW'(i)) begin
                errors++; $display("FAIL prime_addr[%0d]: got %h want %h", i, got_addr[i], b + AW'(i));
            end
        end
        for (int i = 0; i < got_px.size() && i < PRIME * W; i++) begin
            checks++; if (got_px[i] !== exp_px(b, i)) begin
                errors++; $display("FAIL prime_px[%0d]: got %h want %h", i, got_px[i], exp_px(b, i));
            end
        end
        seq_ok = (vcyc.size() == PRIME * W);
        for (int i = 1; i < vcyc.size(); i++)
            if (vcyc[i] != vcyc[0] + i) seq_ok = 1'b0;
        checks++; if (!seq_ok) begin errors++; $display("FAIL prime_gapless: valids not on consecutive cycles (n=%0d)", vcyc.size()); end
        checks++; if (busy !== 1'b1 || done_cnt != 0) begin
            errors++; $display("FAIL prime_wait_state: busy=%b done_cnt=%0d want 1 0", busy, done_cnt);
        end
        do_abort();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL prime_abort_busy: got %b want 0", busy); end
    endtask

    task automatic test_full_frame();
        logic [AW-1:0] b;
        bit ok;
        int last_intr_cyc;
        random_base(b);
        clear_mon();
        do_start(b);
        wait_px(PRIME * W, 200, ok);
        checks++; if (!ok) begin errors++; $display("FAIL frame_prime_timeout: got %0d px want %0d", got_px.size(), PRIME * W); end
        last_intr_cyc = 0;
        for (int r = 0; r < TOT_ROWS; r++) begin
            repeat (20) @(negedge clk);
            if (r == TOT_ROWS - 1) begin
                checks++; if (done_cnt != 0) begin errors++; $display("FAIL frame_early_done: done_cnt=%0d want 0 before last intr", done_cnt); end
            end
            pulse_intr();
            last_intr_cyc = cyc;
            if (exp_lines(r + 1) > exp_lines(r)) begin
                wait_px(exp_lines(r + 1) * W, 200, ok);
                checks++; if (!ok) begin
                    errors++; $display("FAIL frame_line_timeout[%0d]: got %0d px want %0d", r, got_px.size(), exp_lines(r + 1) * W);
                end
            end
        end
        for (int i = 0; i < 40 && done_cnt == 0; i++) @(negedge clk);
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
        checks++; if (got_px.size() != TOT_LINES * W) begin
            errors++; $display("FAIL frame_px_count: got %0d want %0d", got_px.size(), TOT_LINES * W);
        end
        checks++; if (got_addr.size() != H * W) begin
            errors++; $display("FAIL frame_read_count: got %0d want %0d", got_addr.size(), H * W);
        end
        for (int i = 0; i < got_px.size() && i < TOT_LINES * W; i++) begin
            checks++; if (got_px[i] !== exp_px(b, i)) begin
                errors++; $display("FAIL frame_px[%0d]: got %h want %h", i, got_px[i], exp_px(b, i));
            end
        end
        checks++; if (rows !== 16'(TOT_ROWS)) begin errors++; $display("FAIL frame_rows: got %0d want %0d", rows, TOT_ROWS); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy_after_done: got %b want 0", busy); end
        checks++; if (cyc <= last_intr_cyc - 2) begin errors++; $display("FAIL frame_done_order: cyc=%0d intr=%0d", cyc, last_intr_cyc); end
    endtask

    task automatic test_burst_credit();
        logic [AW-1:0] b;
        bit ok;
        int n;
        random_base(b);
        clear_mon();
        do_start(b);
        wait_px(PRIME * W, 200, ok);
        pulse_intr();
        wait_addr(PRIME * W + 2, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL burst_line_start: got %0d reads want %0d", got_addr.size(), PRIME * W + 2); end
        pulse_intr();
        repeat ($urandom_range(0, 2)) @(negedge clk);
        pulse_intr();
        n = exp_lines(3) * W;
        wait_px(n, 200, ok);
        repeat (30) @(negedge clk);
        checks++; if (got_px.size() != n) begin errors++; $display("FAIL burst_px_count: got %0d want %0d", got_px.size(), n); end
        for (int i = 0; i < got_px.size() && i < n; i++) begin
            checks++; if (got_px[i] !== exp_px(b, i)) begin
                errors++; $display("FAIL burst_px[%0d]: got %h want %h", i, got_px[i], exp_px(b, i));
            end
        end
        if (vcyc.size() >= n) begin
            checks++; if (vcyc[(PRIME + 2) * W] - vcyc[(PRIME + 2) * W - 1] > 2) begin
                errors++; $display("FAIL burst_back_to_back: gap %0d want <=2", vcyc[(PRIME + 2) * W] - vcyc[(PRIME + 2) * W - 1]);
            end
        end
        checks++; if (rows !== 16'd3) begin errors++; $display("FAIL burst_rows: got %0d want 3", rows); end
        do_abort();
    endtask

    task automatic test_intr_on_consume();
        logic [AW-1:0] b;
        bit ok;
        int n;
        random_base(b);
        clear_mon();
        do_start(b);
        wait_px(PRIME * W, 200, ok);
        pulse_intr();
        wait_addr(PRIME * W + 2, 50, ok);
        pulse_intr();
        wait_addr((PRIME + 1) * W, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL consume_line_end: got %0d reads want %0d", got_addr.size(), (PRIME + 1) * W); end
        pulse_intr();
        n = exp_lines(3) * W;
        repeat (60) @(negedge clk);
        checks++; if (got_px.size() != n) begin errors++; $display("FAIL consume_px_count: got %0d want %0d", got_px.size(), n); end
        if (vcyc.size() > (PRIME + 1) * W) begin
            checks++; if (vcyc[(PRIME + 1) * W] - vcyc[(PRIME + 1) * W - 1] != 2) begin
                errors++; $display("FAIL consume_gap: got %0d want 2", vcyc[(PRIME + 1) * W] - vcyc[(PRIME + 1) * W - 1]);
            end
        end
        checks++; if (rows !== 16'd3) begin errors++; $display("FAIL consume_rows: got %0d want 3", rows); end
        do_abort();
    endtask

    task automatic test_abort();
        logic [AW-1:0] b;
        bit ok;
        random_base(b);
        clear_mon();
        do_start(b);
        wait_addr(14, 50, ok);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL abort_rd_en: got %b want 0", rd_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        repeat (10) @(negedge clk);
        checks++; if (got_addr.size() != 14) begin errors++; $display("FAIL abort_reads: got %0d want 14", got_addr.size()); end
        checks++; if (got_px.size() != 14) begin errors++; $display("FAIL abort_valids: got %0d want 14", got_px.size()); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || got_addr.size() != 14) begin
            errors++; $display("FAIL start_abort_idle: busy=%b reads=%0d want 0 14", busy, got_addr.size());
        end
        clear_mon();
        do_start(b);
        wait_px(PRIME * W, 200, ok);
        checks++; if (got_addr.size() < 1 || got_addr[0] !== b) begin
            errors++; $display("FAIL restart_first_addr: got %h want %h", got_addr.size() ? got_addr[0] : '0, b);
        end
        for (int i = 0; i < got_px.size() && i < PRIME * W; i++) begin
            checks++; if (got_px[i] !== exp_px(b, i)) begin
                errors++; $display("FAIL restart_px[%0d]: got %h want %h", i, got_px[i], exp_px(b, i));
            end
        end
        do_abort();
    endtask

    task automatic test_async_reset();
        logic [AW-1:0] b1, b2;
        bit ok;
        random_base(b1);
        clear_mon();
        do_start(b1);
        wait_px(PRIME * W, 200, ok);
        pulse_intr();
        wait_addr(PRIME * W + 3, 50, ok);
        checks++; if (busy !== 1'b1 || rows !== 16'd1) begin
            errors++; $display("FAIL areset_pre: busy=%b rows=%0d want 1 1", busy, rows);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if ({rd_en, pv, busy, done} !== 4'b0000) begin
            errors++; $display("FAIL areset_strobes: rd_en/valid/busy/done=%b want 0000", {rd_en, pv, busy, done});
        end
        checks++; if (addr !== '0 || px !== 8'h00 || rows !== 16'd0) begin
            errors++; $display("FAIL areset_values: addr=%h px=%h rows=%0d want 0", addr, px, rows);
        end
        @(negedge clk);
        rst = 1'b0;
        random_base(b1);
        b2 = b1 ^ 18'h2000;
        clear_mon();
        do_start(b1);
        repeat (5) @(negedge clk);
        do_start(b2);
        wait_px(PRIME * W, 200, ok);
        repeat (10) @(negedge clk);
        checks++; if (got_addr.size() != PRIME * W) begin
            errors++; $display("FAIL busy_start_reads: got %0d want %0d", got_addr.size(), PRIME * W);
        end
        for (int i = 0; i < got_addr.size() && i < PRIME * W; i++) begin
            checks++; if (got_addr[i] !== b1 + AW'(i)) begin
                errors++; $display("FAIL busy_start_addr[%0d]: got %h want %h", i, got_addr[i], b1 + AW'(i));
            end
        end
        do_abort();
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            mem[i] = 8'($urandom);
        test_reset();
        test_prime();
        test_full_frame();
        test_burst_credit();
        test_intr_on_consume();
        test_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
